// File: rtl/cpu_pkg.sv
// Shared constants, register-index type and write-strobe helpers for the
// TTL16 register file.
package cpu_pkg;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  typedef logic [AW-1:0] addr_t;

  // Exactly one strobe bit set.
  function automatic logic is_onehot16(input logic [15:0] v);
    return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
  endfunction

  function automatic logic popcount_gt1(input logic [15:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      cnt += 32'(v[i]);
    end
    return cnt > 1;
  endfunction

endpackage

// File: rtl/reg_read_port.sv
// Registered read port with same-edge write bypass; a multi-hot strobe
// never bypasses.
module reg_read_port
  import cpu_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_regs [DEPTH],
  input  addr_t            i_addr,
  input  logic [DEPTH-1:0] i_we,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic             w_hit;
  logic [WIDTH-1:0] r_q;

  assign w_hit = is_onehot16(i_we) && i_we[i_addr];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= w_hit ? i_d : i_regs[i_addr];
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/reg_file_16x16.sv
// Sixteen 16-bit registers fed by one-hot write strobes, with two registered
// bypassing read ports and a sticky flag for illegal multi-hot strobes.
module reg_file_16x16
  import cpu_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [DEPTH-1:0] i_we,
  input  logic [WIDTH-1:0] i_d,
  input  addr_t            i_ra,
  input  addr_t            i_rb,
  input  logic             i_clr_err,
  output logic [WIDTH-1:0] o_qa,
  output logic [WIDTH-1:0] o_qb,
  output logic             o_err
);

  logic [WIDTH-1:0] r_regs [DEPTH];
  logic             r_err;
  logic             w_legal;
  logic             w_multi;

  assign w_legal = is_onehot16(i_we);
  assign w_multi = popcount_gt1(i_we);

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!i_rst_n) begin
        r_regs[i] <= '0;
      end else if (w_legal && i_we[i]) begin
        r_regs[i] <= i_d;
      end
    end
  end

  // Set has priority over clear.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_err <= 1'b0;
    end else if (w_multi) begin
      r_err <= 1'b1;
    end else if (i_clr_err) begin
      r_err <= 1'b0;
    end
  end

  assign o_err = r_err;

  reg_read_port u_port_a (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_regs  (r_regs),
    .i_addr  (i_ra),
    .i_we    (i_we),
    .i_d     (i_d),
    .o_q     (o_qa)
  );

  reg_read_port u_port_b (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_regs  (r_regs),
    .i_addr  (i_rb),
    .i_we    (i_we),
    .i_d     (i_d),
    .o_q     (o_qb)
  );

endmodule
